// File: rtl/seq_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter_pkg
// Description : Shared types and helpers for the sequential shifter.
//               mode_e  - operation select carried on in_mode
//               state_e - control FSM encoding
//               min_step - per-cycle shift amount, min(step, remaining)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_shifter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    function automatic int min_step(input int step, input int remaining);
        return (step < remaining) ? step : remaining;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter_if
// Description : Operand/result handshake bundle for seq_shifter.
//               in_valid/in_ready/in_data/in_mode/in_shamt : operand request
//               out_valid/out_ready/out_data               : result
//               busy                                       : block not idle
//               master = operand source / result sink, slave = the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_shifter_if #(
    parameter int IN_W = 4
) ();
    localparam int OUT_W   = 2 * IN_W;
    localparam int SHAMT_W = $clog2(OUT_W);

    logic                                in_valid;
    logic                                in_ready;
    logic [IN_W-1:0]                     in_data;
    logic [seq_shifter_pkg::MODE_W-1:0]  in_mode;
    logic [SHAMT_W-1:0]                  in_shamt;
    logic                                out_valid;
    logic                                out_ready;
    logic [OUT_W-1:0]                    out_data;
    logic                                busy;

    modport master (
        output in_valid, in_data, in_mode, in_shamt, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_shamt, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_shifter_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : One combinational shift step of the accumulator.
//               acc      in  OUT_W   current accumulator
//               n        in  SHAMT_W bits to shift this step
//               mode     in  mode_e  SLL / SRL / SRA / ROL
//               acc_next out OUT_W   shifted accumulator
//               Macro SEQ_SHIFTER_ROTATE_EN: when defined, MODE_ROL rotates
//               left; otherwise MODE_ROL passes acc through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int OUT_W   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic [OUT_W-1:0]   acc,
    input  logic [SHAMT_W-1:0] n,
    input  mode_e              mode,
    output logic [OUT_W-1:0]   acc_next
);

`ifdef SEQ_SHIFTER_ROTATE_EN
    // One bit wider than n so that n==0 yields a wrap shift of OUT_W,
    // which shifts everything out and leaves the rotate as a plain copy.
    logic [SHAMT_W:0] rot_back;
    assign rot_back = (SHAMT_W+1)'(OUT_W) - {1'b0, n};
`endif

    always_comb begin
        acc_next = acc;
        case (mode)
            MODE_SLL: acc_next = acc << n;
            MODE_SRL: acc_next = acc >> n;
            MODE_SRA: acc_next = $signed(acc) >>> n;
            MODE_ROL: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
                acc_next = (acc << n) | (acc >> rot_back);
`else
                acc_next = acc;
`endif
            end
            default:  acc_next = acc;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Multi-cycle shifter. Extends an IN_W operand to 2*IN_W bits
//               (sign-extend for SRA, zero-extend otherwise) and shifts it by
//               in_shamt, at most STEP bits per cycle.
//               clk  in  clock, rising edge
//               rst  in  asynchronous reset, active-high
//               bus  seq_shifter_if.slave (operand in, result out, busy)
//               Macro SEQ_SHIFTER_ROTATE_EN: mode 11 rotates left when
//               defined; otherwise mode 11 is a pass-through of the
//               zero-extended operand with latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int IN_W = 4,
    parameter int STEP = 1
) (
    input  logic         clk,
    input  logic         rst,
    seq_shifter_if.slave bus
);
    localparam int OUT_W   = 2 * IN_W;
    localparam int SHAMT_W = $clog2(OUT_W);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] remaining_q, remaining_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;

    logic [SHAMT_W-1:0] step_n;
    logic [OUT_W-1:0]   acc_shifted;
    mode_e              in_mode_w;
    logic               pass_w;

    assign in_mode_w = mode_e'(bus.in_mode);
    assign step_n    = SHAMT_W'(min_step(STEP, int'(remaining_q)));

`ifdef SEQ_SHIFTER_ROTATE_EN
    assign pass_w = 1'b0;
`else
    assign pass_w = (in_mode_w == MODE_ROL);
`endif

    shift_step #(
        .OUT_W   (OUT_W),
        .SHAMT_W (SHAMT_W)
    ) u_shift_step (
        .acc      (acc_q),
        .n        (step_n),
        .mode     (mode_q),
        .acc_next (acc_shifted)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mode_d      = in_mode_w;
                    remaining_d = bus.in_shamt;
                    if (in_mode_w == MODE_SRA)
                        acc_d = {{IN_W{bus.in_data[IN_W-1]}}, bus.in_data};
                    else
                        acc_d = {{IN_W{1'b0}}, bus.in_data};
                    state_d = ((bus.in_shamt == '0) || pass_w) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d       = acc_shifted;
                remaining_d = remaining_q - step_n;
                if (remaining_q == step_n)
                    state_d = DONE;
            end
            DONE: begin
                // Leave only once the result has actually been presented.
                if (out_valid_q && bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // out_valid rises the cycle after DONE is entered and drops on the
        // handshake edge, so the result is offered exactly once.
        out_valid_d = (state_q == DONE) && !(out_valid_q && bus.out_ready);
        out_data_d  = out_valid_d ? acc_q : '0;
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= MODE_SLL;
            acc_q       <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Scoreboard bench for seq_shifter, IN_W=4. Instance 1 uses
//               STEP=1, instance 2 uses STEP=2. Drivers push expected
//               results at the accept edge; monitors pop on out_valid rise.
//               Mode 11 expectations follow SEQ_SHIFTER_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb1[$];
    exp_t sb2[$];

    seq_shifter_if #(.IN_W(4)) bus1 ();
    seq_shifter_if #(.IN_W(4)) bus2 ();

    seq_shifter #(.IN_W(4), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    seq_shifter #(.IN_W(4), .STEP(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic send(input int sel, input logic [3:0] d, input logic [1:0] m,
                        input logic [2:0] s, input logic [7:0] e, input int lat, input bit track);
        int t;
        t = 0;
        @(negedge clk);
        if (sel == 1) begin
            bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_mode = m; bus1.in_shamt = s;
        end else begin
            bus2.in_valid = 1'b1; bus2.in_data = d; bus2.in_mode = m; bus2.in_shamt = s;
        end
        while (((sel == 1) ? bus1.in_ready : bus2.in_ready) == 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL accept timeout dut%0d", sel);
        end else if (track) begin
            // in_ready seen high here, so the operand is taken on the next edge.
            if (sel == 1) sb1.push_back('{e, lat, cyc + 1});
            else          sb2.push_back('{e, lat, cyc + 1});
        end
        @(negedge clk);
        if (sel == 1) bus1.in_valid = 1'b0;
        else          bus2.in_valid = 1'b0;
    endtask

    task automatic drain(input int sel);
        int t;
        t = 0;
        while (t < 100 && (((sel == 1) ? sb1.size() : sb2.size()) != 0 ||
                           ((sel == 1) ? bus1.in_ready : bus2.in_ready) == 1'b0)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL drain timeout dut%0d", sel);
        end
    endtask

    task automatic monitor(input int sel);
        exp_t       e;
        logic       pv;
        logic       v;
        logic [7:0] d;
        logic [7:0] held;
        pv   = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            v = (sel == 1) ? bus1.out_valid : bus2.out_valid;
            d = (sel == 1) ? bus1.out_data  : bus2.out_data;
            if (v) begin
                if (!pv) begin
                    if (((sel == 1) ? sb1.size() : sb2.size()) == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL dut%0d unexpected out_valid: got data %0h expected none", sel, d);
                    end else begin
                        e = (sel == 1) ? sb1.pop_front() : sb2.pop_front();
                        chk($sformatf("dut%0d out_data", sel), 32'(d), 32'(e.data));
                        chk($sformatf("dut%0d latency", sel), 32'(cyc - e.acc_cyc), 32'(e.lat));
                    end
                end else begin
                    chk($sformatf("dut%0d out_data hold", sel), 32'(d), 32'(held));
                end
                held = d;
            end else begin
                chk($sformatf("dut%0d out_data zero", sel), 32'(d), 32'h0);
            end
            pv = v;
        end
    endtask

    initial monitor(1);
    initial monitor(2);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_mode = '0; bus1.in_shamt = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.in_mode = '0; bus2.in_shamt = '0; bus2.out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        chk("reset in_ready", 32'(bus1.in_ready), 32'h1);
        chk("reset out_valid", 32'(bus1.out_valid), 32'h0);
        chk("reset busy", 32'(bus1.busy), 32'h0);
        chk("reset in_ready dut2", 32'(bus2.in_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, STEP=1
        send(1, 4'hB, 2'b00, 3'd2, 8'h2C, 3, 1'b1); drain(1);
        send(1, 4'hA, 2'b01, 3'd3, 8'h01, 4, 1'b1); drain(1);
        send(1, 4'hA, 2'b10, 3'd3, 8'hFF, 4, 1'b1); drain(1);
        send(1, 4'h5, 2'b00, 3'd0, 8'h05, 1, 1'b1); drain(1);
        send(1, 4'hF, 2'b00, 3'd7, 8'h80, 8, 1'b1); drain(1);
`ifdef SEQ_SHIFTER_ROTATE_EN
        send(1, 4'h9, 2'b11, 3'd5, 8'h21, 6, 1'b1); drain(1);
`else
        send(1, 4'h9, 2'b11, 3'd5, 8'h09, 1, 1'b1); drain(1);
`endif

        // STEP=2, including a remainder step
        send(2, 4'h1, 2'b00, 3'd7, 8'h80, 5, 1'b1); drain(2);
        send(2, 4'h9, 2'b10, 3'd5, 8'hFF, 4, 1'b1); drain(2);
        send(2, 4'hF, 2'b01, 3'd7, 8'h00, 5, 1'b1); drain(2);

        // Backpressure: result held, new operands ignored
        bus1.out_ready = 1'b0;
        send(1, 4'h8, 2'b10, 3'd1, 8'hFC, 2, 1'b1);
        begin
            int t;
            t = 0;
            while (!bus1.out_valid && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) begin n_cmp++; n_err++; $display("FAIL backpressure out_valid timeout"); end
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 32'(bus1.out_valid), 32'h1);
            chk("bp in_ready", 32'(bus1.in_ready), 32'h0);
            chk("bp busy", 32'(bus1.busy), 32'h1);
            bus1.in_valid = 1'b1; bus1.in_data = 4'h3; bus1.in_mode = 2'b00; bus1.in_shamt = 3'd1;
            @(negedge clk);
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(bus1.in_ready), 32'h1);
        chk("bp release out_valid", 32'(bus1.out_valid), 32'h0);
        chk("bp release busy", 32'(bus1.busy), 32'h0);

        // Reset in the middle of a shift: no result may appear
        send(1, 4'h1, 2'b00, 3'd7, 8'h00, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid-rst out_valid", 32'(bus1.out_valid), 32'h0);
        chk("mid-rst out_data", 32'(bus1.out_data), 32'h0);
        chk("mid-rst busy", 32'(bus1.busy), 32'h0);
        chk("mid-rst in_ready", 32'(bus1.in_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(1, 4'h3, 2'b00, 3'd4, 8'h30, 5, 1'b1); drain(1);

        repeat (5) @(negedge clk);
        chk("sb1 empty", 32'(sb1.size()), 32'h0);
        chk("sb2 empty", 32'(sb2.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
